// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - ALU control encodings, funct codes, op classes and FSM states
// Optional illegal-funct trapping is enabled by ALU_CTRL_ILLEGAL_TRAP_EN.
package alu_ctrl_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLL = 3'b101;
  localparam logic [2:0] ALU_SRL = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [3:0] FUNCT_ADD = 4'b0000;
  localparam logic [3:0] FUNCT_SUB = 4'b0001;
  localparam logic [3:0] FUNCT_AND = 4'b0010;
  localparam logic [3:0] FUNCT_OR  = 4'b0011;
  localparam logic [3:0] FUNCT_XOR = 4'b0100;
  localparam logic [3:0] FUNCT_SLL = 4'b0101;
  localparam logic [3:0] FUNCT_SRL = 4'b0110;
  localparam logic [3:0] FUNCT_SLT = 4'b0111;
  localparam logic [3:0] FUNCT_MUL = 4'b1000;

  localparam logic [1:0] OP_FUNCT = 2'd0;
  localparam logic [1:0] OP_ADD   = 2'd1;
  localparam logic [1:0] OP_SUB   = 2'd2;
  localparam logic [1:0] OP_SLT   = 2'd3;

`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FULL = 2'd1,
    S_MUL  = 2'd2
  } state_e;

endpackage

// File: rtl/alu_funct_decode.sv
// rtl/alu_funct_decode.sv - combinational (alu_op, funct) to (ctrl, is_mul, illegal) map
// Illegal reporting depends on ALU_CTRL_ILLEGAL_TRAP_EN (via alu_ctrl_pkg::TRAP_EN).
module alu_funct_decode
  import alu_ctrl_pkg::*;
#(
  parameter int OPW   = 2,
  parameter int FUNCW = 4
) (
  input  logic [OPW-1:0]   alu_op,
  input  logic [FUNCW-1:0] funct,
  output logic [2:0]       ctrl,
  output logic             is_mul,
  output logic             illegal
);

  logic [1:0] op_cls;
  logic [3:0] f_lo;
  logic       f_hi_nz;
  logic       bad;

  always_comb begin
    op_cls  = 2'(alu_op);
    f_lo    = funct[3:0];
    f_hi_nz = (funct >> 4) != '0;
    ctrl    = ALU_ADD;
    is_mul  = 1'b0;
    bad     = 1'b0;
    case (op_cls)
      OP_ADD: ctrl = ALU_ADD;
      OP_SUB: ctrl = ALU_SUB;
      OP_SLT: ctrl = ALU_SLT;
      default: begin
        if (f_hi_nz) begin
          bad = 1'b1;
        end else begin
          case (f_lo)
            FUNCT_ADD: ctrl = ALU_ADD;
            FUNCT_SUB: ctrl = ALU_SUB;
            FUNCT_AND: ctrl = ALU_AND;
            FUNCT_OR:  ctrl = ALU_OR;
            FUNCT_XOR: ctrl = ALU_XOR;
            FUNCT_SLL: ctrl = ALU_SLL;
            FUNCT_SRL: ctrl = ALU_SRL;
            FUNCT_SLT: ctrl = ALU_SLT;
            FUNCT_MUL: is_mul = 1'b1;
            default:   bad = 1'b1;
          endcase
        end
      end
    endcase
    // Undecodable beats always present ADD; only the flag differs by build.
    illegal = bad & TRAP_EN;
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// rtl/alu_ctrl_seq.sv - registered, handshaked ALU control decoder with multiply stall
// Illegal-funct trap and sticky error are enabled by ALU_CTRL_ILLEGAL_TRAP_EN.
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int OPW     = 2,
  parameter int FUNCW   = 4,
  parameter int CTRLW   = 3,
  parameter int MUL_LAT = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   in_alu_op,
  input  logic [FUNCW-1:0] in_funct,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CTRLW-1:0] out_ctrl,
  output logic             out_is_mul,
  output logic             out_illegal,
  output logic             mul_busy,
  output logic             err_sticky,
  input  logic             err_clr
);

  localparam int CNTW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  state_e          state, state_nxt;
  logic [CNTW-1:0] cnt, cnt_nxt;
  logic [2:0]      dec_ctrl;
  logic            dec_is_mul;
  logic            dec_illegal;
  logic            accept;

  alu_funct_decode #(
    .OPW   (OPW),
    .FUNCW (FUNCW)
  ) u_dec (
    .alu_op  (in_alu_op),
    .funct   (in_funct),
    .ctrl    (dec_ctrl),
    .is_mul  (dec_is_mul),
    .illegal (dec_illegal)
  );

  // in_ready depends only on state and out_ready, never on in_valid.
  assign in_ready  = (state == S_IDLE) || ((state == S_FULL) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == S_FULL);
  assign mul_busy  = (state == S_MUL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE, S_FULL: begin
        if (accept) begin
          if (dec_is_mul) begin
            state_nxt = S_MUL;
            cnt_nxt   = CNTW'(MUL_LAT - 1);
          end else begin
            state_nxt = S_FULL;
          end
        end else if (state == S_FULL && out_ready) begin
          state_nxt = S_IDLE;
        end
      end
      S_MUL: begin
        if (cnt == '0) state_nxt = S_FULL;
        else           cnt_nxt   = cnt - CNTW'(1);
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_ctrl    <= '0;
      out_is_mul  <= 1'b0;
      out_illegal <= 1'b0;
      err_sticky  <= 1'b0;
    end else begin
      if (accept) begin
        out_ctrl    <= CTRLW'(dec_ctrl);
        out_is_mul  <= dec_is_mul;
        out_illegal <= dec_illegal;
      end
      // A new illegal accept outranks a same-cycle clear.
      err_sticky <= TRAP_EN && ((accept && dec_illegal) || (err_sticky && !err_clr));
    end
  end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// tb/tb_alu_ctrl_seq.sv - scoreboard bench for alu_ctrl_seq (honours ALU_CTRL_ILLEGAL_TRAP_EN)
module tb_alu_ctrl_seq;

`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  typedef struct packed {
    logic [2:0] ctrl;
    logic       is_mul;
    logic       illegal;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [1:0] in_alu_op = '0;
  logic [3:0] in_funct = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [2:0] out_ctrl;
  logic       out_is_mul;
  logic       out_illegal;
  logic       mul_busy;
  logic       err_sticky;
  logic       err_clr = 1'b0;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];
  exp_t mon_e;

  logic [1:0] s_ops [8] = '{2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd3, 2'd0, 2'd0};
  logic [3:0] s_fns [8] = '{4'd0, 4'd5, 4'd1, 4'd7, 4'd2, 4'd9, 4'd4, 4'd6};

  alu_ctrl_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_alu_op   (in_alu_op),
    .in_funct    (in_funct),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_ctrl    (out_ctrl),
    .out_is_mul  (out_is_mul),
    .out_illegal (out_illegal),
    .mul_busy    (mul_busy),
    .err_sticky  (err_sticky),
    .err_clr     (err_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [1:0] op, input logic [3:0] fn);
    exp_t e;
    e = '0;
    if (op == 2'd1)      e.ctrl = 3'b000;
    else if (op == 2'd2) e.ctrl = 3'b001;
    else if (op == 2'd3) e.ctrl = 3'b111;
    else if (fn < 4'd8)  e.ctrl = fn[2:0];
    else if (fn == 4'd8) e.is_mul = 1'b1;
    else                 e.illegal = TRAP;
    return e;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Output beats are popped when consumed; accepted input beats are pushed.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        check("sb_nonempty", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          check("sb_ctrl", out_ctrl, mon_e.ctrl);
          check("sb_is_mul", out_is_mul, mon_e.is_mul);
          check("sb_illegal", out_illegal, mon_e.illegal);
        end
      end
      if (in_valid && in_ready) sb.push_back(model(in_alu_op, in_funct));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_hold_valid", out_valid, 0);
    check("rst_hold_busy", mul_busy, 0);
    #3 rst_n = 1'b1;
    tick();
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_ctrl", out_ctrl, 0);
    check("rst_is_mul", out_is_mul, 0);
    check("rst_illegal", out_illegal, 0);
    check("rst_mul_busy", mul_busy, 0);
    check("rst_err", err_sticky, 0);

    // Single OR beat, one-cycle latency
    tick();
    in_valid = 1'b1; in_alu_op = 2'd0; in_funct = 4'b0011; out_ready = 1'b1;
    @(negedge clk);
    check("or_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("or_valid", out_valid, 1);
    check("or_ctrl", out_ctrl, 3'b011);
    check("or_is_mul", out_is_mul, 0);
    tick();
    @(negedge clk);
    check("or_drained", out_valid, 0);

    // Eight back-to-back beats with no bubble
    for (int i = 0; i < 8; i++) begin
      tick();
      in_valid = 1'b1; in_alu_op = s_ops[i]; in_funct = s_fns[i];
      @(negedge clk);
      check("stream_rdy", in_ready, 1);
      if (i > 0) check("stream_vld", out_valid, 1);
    end
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("stream_last_vld", out_valid, 1);
    tick();
    @(negedge clk);
    check("stream_drained", out_valid, 0);

    // Multiply stalls issue for MUL_LAT cycles
    tick();
    in_valid = 1'b1; in_alu_op = 2'd0; in_funct = 4'b1000;
    @(negedge clk);
    check("mul_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("mul_busy", mul_busy, 1);
      check("mul_stall_rdy", in_ready, 0);
      check("mul_no_valid", out_valid, 0);
      tick();
    end
    @(negedge clk);
    check("mul_valid", out_valid, 1);
    check("mul_is_mul", out_is_mul, 1);
    check("mul_ctrl", out_ctrl, 0);
    check("mul_busy_done", mul_busy, 0);
    tick();

    // Backpressure holds the output register
    in_valid = 1'b1; in_alu_op = 2'd0; in_funct = 4'b0100; out_ready = 1'b0;
    tick();
    in_funct = 4'b0110;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_valid", out_valid, 1);
      check("bp_ctrl", out_ctrl, 3'b100);
      check("bp_rdy", in_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_rdy", in_ready, 1);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_next_valid", out_valid, 1);
    check("bp_next_ctrl", out_ctrl, 3'b110);
    tick();

    // Illegal funct and sticky error with set-over-clear
    in_valid = 1'b1; in_alu_op = 2'd0; in_funct = 4'b1111;
    tick();
    err_clr = 1'b1;
    @(negedge clk);
    check("ill_flag", out_illegal, TRAP);
    check("ill_ctrl", out_ctrl, 0);
    check("ill_is_mul", out_is_mul, 0);
    check("ill_sticky", err_sticky, TRAP);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("ill_set_wins", err_sticky, TRAP);
    check("ill_flag2", out_illegal, TRAP);
    tick();
    err_clr = 1'b0;
    @(negedge clk);
    check("ill_cleared", err_sticky, 0);
    check("ill_drained", out_valid, 0);

    // Reset during the second multiply cycle discards the beat
    tick();
    in_valid = 1'b1; in_alu_op = 2'd0; in_funct = 4'b1000;
    tick();
    in_valid = 1'b0;
    tick();
    #1 rst_n = 1'b0;
    sb.delete();
    #1;
    check("mrst_valid", out_valid, 0);
    check("mrst_busy", mul_busy, 0);
    check("mrst_ctrl", out_ctrl, 0);
    check("mrst_is_mul", out_is_mul, 0);
    check("mrst_in_ready", in_ready, 1);
    @(negedge clk);
    #3 rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("mrst_no_beat", out_valid, 0);
      check("mrst_idle_busy", mul_busy, 0);
    end

    check("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_seq.md
# alu_ctrl_seq

Registered, handshaked successor to the CPU_16Bit ALU control decoder. It accepts an ALU-operation class and a function field from the control unit and instruction memory, then presents a registered ALU control word to the datapath ALU. It adds parametrised field widths, valid/ready flow control, and a multi-cycle multiply sequencing state that stalls issue. It sits between the decode stage (cu, InstrMemory) and the ALU.

## Interface
Parameters:
- OPW, 2: width of alu_op class field
- FUNCW, 4: width of function field; must be ≥ 4
- CTRLW, 3: width of ALU control word; must be ≥ 3
- MUL_LAT, 3: multiply busy cycles; must be ≥ 1

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  decode beat valid
- in_ready  out  1  block can accept a beat this cycle
- in_alu_op  in  OPW  operation class
- in_funct  in  FUNCW  function field
- out_valid  out  1  registered control word valid
- out_ready  in  1  ALU consumes the beat
- out_ctrl  out  CTRLW  ALU control word
- out_is_mul  out  1  beat is a multiply
- out_illegal  out  1  function field undecodable
- mul_busy  out  1  multiply sequencing in progress
- err_sticky  out  1  sticky illegal flag
- err_clr  in  1  clears err_sticky

## Operation
- Class decode of in_alu_op:
  - 0: use funct
  - 1: force ADD (load/store)
  - 2: force SUB (branch)
  - 3: force SLT
  - Upper bits beyond 2 are ignored.
- Funct decode (low 4 bits; higher funct bits must be zero, else illegal):
  - 0000 ADD→000, 0001 SUB→001, 0010 AND→010, 0011 OR→011, 0100 XOR→100, 0101 SLL→101, 0110 SRL→110, 0111 SLT→111
  - 1000 MUL→ctrl 000 with is_mul=1
  - any other value → illegal
- out_ctrl is zero-extended to CTRLW.
- FSM states: S_IDLE (empty), S_FULL (out_valid=1), S_MUL (counting).
- in_ready = (S_IDLE) or (S_FULL and out_ready). in_ready is 0 in S_MUL.
- Accept occurs when in_valid and in_ready. On accept, the decoded result is loaded into the output register. Next state:
  - MUL → S_MUL, cnt = MUL_LAT-1
  - otherwise → S_FULL
- S_MUL: mul_busy=1, out_valid=0, cnt decrements each cycle. When cnt==0, the next state is S_FULL and the MUL beat is presented.
- S_FULL with out_ready and no accept → S_IDLE.
- S_FULL with out_ready and accept → back-to-back; no bubble.
- Output register holds stable while out_valid and !out_ready.
- err_sticky sets on accept of an illegal beat. It clears on err_clr; set wins over a simultaneous clear.

## Timing
- Reset (async assert, sync-safe deassert):
  - state=S_IDLE, cnt=0
  - out_valid=0, out_ctrl=0, out_is_mul=0, out_illegal=0, mul_busy=0, err_sticky=0
  - in_ready=1 from the first cycle after reset
- Non-MUL latency: 1 cycle. A beat accepted at edge N has out_valid high after edge N.
- MUL latency: 1+MUL_LAT cycles to out_valid.
- Throughput:
  - non-MUL: 1 beat per cycle
  - MUL: in_ready is low for exactly MUL_LAT cycles after accept
- Reset mid-S_MUL discards the pending beat. No output beat follows reset.
- in_ready is combinational from state and out_ready only. No path exists from in_valid to in_ready.

## Configuration
- ALU_CTRL_ILLEGAL_TRAP_EN defined: illegal beats set out_illegal=1 with out_ctrl=000, and err_sticky behaves as above.
- ALU_CTRL_ILLEGAL_TRAP_EN undefined: illegal beats decode as ADD (000); out_illegal and err_sticky are tied to 0; err_clr is ignored.

## Structure
- Package alu_ctrl_pkg:
  - ALU control encodings (ALU_ADD…ALU_SLT)
  - funct codes including FUNCT_MUL
  - alu_op class constants
  - FSM state enum
- Sub-module alu_funct_decode: purely combinational. Maps (alu_op, funct) to (ctrl, is_mul, illegal). Instantiated once; FSM, counter and registers live in the top.

## Test plan
- Reset held, then released with in_valid=0 → all outputs 0, in_ready=1, state S_IDLE.
- alu_op=0, funct=0011, out_ready=1 → next cycle out_valid=1, out_ctrl=011, out_is_mul=0. Stream of 8 back-to-back beats drains with no bubble.
- alu_op=0, funct=1000, MUL_LAT=3 → mul_busy=1 and in_ready=0 for 3 cycles; out_valid=1 on cycle 4 with out_is_mul=1, out_ctrl=000.
- out_ready=0 with out_valid=1 for 5 cycles → out_ctrl stable and in_ready=0; release → next beat accepted same cycle.
- funct=1111 with trap enabled → out_illegal=1, err_sticky=1; err_clr plus a simultaneous new illegal beat → err_sticky stays 1. Trap disabled → out_ctrl=000, out_illegal=0.
- rst_n asserted during S_MUL cycle 2 → outputs to reset values immediately; after release, no out_valid without a new accept.
